// File: rtl/mux_scan_sampler_pkg.sv
// mux_scan_pkg: shared constants and the sequencer state type for the
// 16:1 mux scan sampler.
//   SEL_W      : select width driven to the mux
//   N_CH       : channel count (always 2**SEL_W)
//   SETTLE_MAX : largest legal settle time, sizes the settle counter
package mux_scan_pkg;

   localparam int unsigned SEL_W      = 4;
   localparam int unsigned N_CH       = 16;
   localparam int unsigned SETTLE_MAX = 15;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      SAMPLE = 2'd2
   } state_t;

endpackage

// File: rtl/mux_scan_sampler_if.sv
// mux_scan_sampler_if: downstream frame handshake of the scan sampler.
//   frame       : captured frame, bit i = sample of channel i
//   frame_valid : frame holds an unconsumed result
//   frame_ready : downstream accepts the frame
// master = sampler side, slave = consumer side.
interface mux_scan_sampler_if #(
   parameter int unsigned N_CH = mux_scan_pkg::N_CH
);

   logic [N_CH-1:0] frame;
   logic            frame_valid;
   logic            frame_ready;

   modport master (output frame, output frame_valid, input frame_ready);
   modport slave  (input frame, input frame_valid, output frame_ready);

endinterface

// File: rtl/mux_scan_sampler_settle_cnt.sv
// scan_settle_cnt: loadable down-counter timing the mux settle window.
//   clk, rst   : clock, synchronous active-high reset
//   i_load     : load i_load_val (has priority over decrement)
//   i_load_val : value to load
//   i_dec      : decrement by one, saturating at zero
//   o_zero     : counter value is zero
module scan_settle_cnt
   import mux_scan_pkg::*;
#(
   parameter int unsigned CNT_W = $clog2(SETTLE_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler: drives the select of a 16:1 bit mux, waits SETTLE
// cycles on each enabled channel, samples the mux bit and assembles a
// frame that is handed downstream over a valid/ready handshake.
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a scan when idle (ignored while busy)
//   stop        : continuous mode: finish current frame, then go idle
//   continuous  : 1 = rescan back-to-back (latched at start)
//   chan_mask   : per-channel enable (latched at start)
//   sel         : registered mux select
//   mux_out     : bit returned by the mux
//   dn          : frame / frame_valid / frame_ready handshake
//   busy        : a scan is in progress
//   overrun     : sticky, a completed frame was dropped
module mux_scan_sampler #(
   parameter int unsigned SEL_W  = mux_scan_pkg::SEL_W,
   parameter int unsigned N_CH   = 2 ** SEL_W,
   parameter int unsigned SETTLE = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic                continuous,
   input  logic [N_CH-1:0]     chan_mask,
   output logic [SEL_W-1:0]    sel,
   input  logic                mux_out,
   mux_scan_sampler_if.master  dn,
   output logic                busy,
   output logic                overrun
);

   import mux_scan_pkg::*;

   localparam int unsigned     CNT_W      = $clog2(SETTLE_MAX + 1);
   localparam bit              HAS_SETTLE = (SETTLE != 0);
   // The sample cycle itself is the last cycle of an enabled slot, so the
   // WAIT state occupies SETTLE-1 .. 0 and a slot lasts SETTLE+1 cycles.
   localparam logic [CNT_W-1:0] LOAD_VAL  = CNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);

   state_t           r_state;
   logic [SEL_W-1:0] r_sel;
   logic [N_CH-1:0]  r_mask;
   logic [N_CH-1:0]  r_shadow;
   logic [N_CH-1:0]  r_frame;
   logic             r_cont;
   logic             r_stop_seen;
   logic             r_busy;
   logic             r_valid;
   logic             r_overrun;

   logic [SEL_W-1:0] w_next_sel;
   logic [N_CH-1:0]  w_shadow_nxt;
   logic             w_last;
   logic             w_complete;
   logic             w_finish;
   logic             w_accept;
   logic             w_cnt_load;
   logic             w_cnt_dec;
   logic             w_cnt_zero;

   always_comb begin
      w_last       = (r_sel == SEL_W'(N_CH - 1));
      // N_CH == 2**SEL_W, so the increment wraps to 0 after the last channel
      w_next_sel   = r_sel + SEL_W'(1);
      w_complete   = (r_state == SAMPLE) && w_last;
      // stop arriving on the completion edge still ends the scan
      w_finish     = !r_cont || r_stop_seen || stop;
      w_accept     = !r_valid || dn.frame_ready;
      w_shadow_nxt = r_shadow;
      w_shadow_nxt[r_sel] = r_mask[r_sel] & mux_out;
      w_cnt_dec    = (r_state == WAIT);
      w_cnt_load   = 1'b0;
      if (HAS_SETTLE) begin
         if (r_state == IDLE) begin
            w_cnt_load = start && chan_mask[0];
         end else if (r_state == SAMPLE) begin
            w_cnt_load = !(w_complete && w_finish) && r_mask[w_next_sel];
         end
      end
   end

   scan_settle_cnt #(
      .CNT_W (CNT_W)
   ) u_settle_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_cnt_load),
      .i_load_val (LOAD_VAL),
      .i_dec      (w_cnt_dec),
      .o_zero     (w_cnt_zero)
   );

   // Sequencer: state, select, latched configuration and shadow register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_sel       <= '0;
         r_mask      <= '0;
         r_cont      <= 1'b0;
         r_stop_seen <= 1'b0;
         r_busy      <= 1'b0;
         r_shadow    <= '0;
      end else begin
         if (r_busy && r_cont && stop) begin
            r_stop_seen <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mask      <= chan_mask;
                  r_cont      <= continuous;
                  r_stop_seen <= 1'b0;
                  r_busy      <= 1'b1;
                  r_sel       <= '0;
                  r_state     <= (HAS_SETTLE && chan_mask[0]) ? WAIT : SAMPLE;
               end
            end
            WAIT: begin
               if (w_cnt_zero) begin
                  r_state <= SAMPLE;
               end
            end
            SAMPLE: begin
               r_shadow <= w_shadow_nxt;
               r_sel    <= w_next_sel;
               if (w_complete && w_finish) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= (HAS_SETTLE && r_mask[w_next_sel]) ? WAIT : SAMPLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Output stage: frame hand-off, backpressure and overrun detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame   <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if ((r_state == IDLE) && start) begin
            r_overrun <= 1'b0;
         end
         if (w_complete) begin
            if (w_accept) begin
               r_frame <= w_shadow_nxt;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && dn.frame_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign sel            = r_sel;
   assign busy           = r_busy;
   assign overrun        = r_overrun;
   assign dn.frame       = r_frame;
   assign dn.frame_valid = r_valid;

endmodule
